// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM scoreboard, operand forwarding, load-use stall,
// branch flush and memory freeze. Optional performance counters via HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic                  dec_rs1_used,
  input  logic                  dec_rs2_used,
  input  logic [REG_ADDR_W-1:0] dec_rd_addr,
  input  logic                  dec_rd_we,
  input  logic                  dec_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  f_to_d_enable_ff,
  output logic                  d_to_e_enable_ff,
  output logic                  d_to_e_bubble,
  output logic                  f_to_d_flush,
  output logic [1:0][1:0]       pipeline_forward_sel,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EX_ALU  = 2'd1,
    FWD_MEM_ALU = 2'd2,
    FWD_MEM_DM  = 2'd3
  } fwd_t;

  state_t state, state_nxt;

  logic                  ex_valid, mem_valid;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd;
  logic                  ex_load, mem_load;

  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [1:0]            src_used;
  logic [1:0]            ex_hit, mem_hit;
  logic                  load_use;
  logic                  dec_writes;

  assign src_addr[0] = dec_rs1_addr;
  assign src_addr[1] = dec_rs2_addr;
  assign src_used    = {dec_rs2_used, dec_rs1_used};
  assign dec_writes  = dec_valid && dec_rd_we && (dec_rd_addr != '0);

  // x0 and unused operands never match, so they always read the register file
  always_comb begin
    ex_hit               = '0;
    mem_hit              = '0;
    pipeline_forward_sel = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (src_used[i] && (src_addr[i] != '0)) begin
        ex_hit[i]  = ex_valid  && (ex_rd  == src_addr[i]);
        mem_hit[i] = mem_valid && (mem_rd == src_addr[i]);
      end
      if (rst) begin
        if (ex_hit[i] && !ex_load) begin
          pipeline_forward_sel[i] = FWD_EX_ALU;
        end else if (mem_hit[i]) begin
          pipeline_forward_sel[i] = mem_load ? FWD_MEM_DM : FWD_MEM_ALU;
        end else begin
          pipeline_forward_sel[i] = FWD_REGFILE;
        end
      end
    end
  end

  assign load_use = dec_valid && ex_load && (|ex_hit) && (state != LOAD_STALL);

  always_comb begin
    state_nxt        = RUN;
    f_to_d_enable_ff = 1'b1;
    d_to_e_enable_ff = 1'b1;
    d_to_e_bubble    = 1'b0;
    f_to_d_flush     = 1'b0;
    if (!rst) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_enable_ff = 1'b0;
      d_to_e_bubble    = 1'b1;
      f_to_d_flush     = 1'b1;
    end else if (mem_busy) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_enable_ff = 1'b0;
      state_nxt        = MEM_WAIT;
    end else if (ex_branch_taken) begin
      d_to_e_bubble    = 1'b1;
      f_to_d_flush     = 1'b1;
    end else if (load_use) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_bubble    = 1'b1;
      state_nxt        = LOAD_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_load   <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_load  <= 1'b0;
    end else if (!mem_busy) begin
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_load  <= ex_load;
      if (d_to_e_bubble) begin
        ex_valid <= 1'b0;
        ex_rd    <= '0;
        ex_load  <= 1'b0;
      end else begin
        ex_valid <= dec_writes;
        ex_rd    <= dec_rd_addr;
        ex_load  <= dec_writes && dec_is_load;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!f_to_d_enable_ff && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (f_to_d_flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed hazard scenarios plus randomized stimulus
// against an in-flight instruction queue model. Counter checks follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 6;
  localparam int          MAXC = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam int          EXP_TWO_STALLS = 2;
`else
  localparam int          EXP_TWO_STALLS = 0;
`endif

  logic              clk;
  logic              rst;
  logic              dec_valid;
  logic [AW-1:0]     dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic              dec_rs1_used, dec_rs2_used, dec_rd_we, dec_is_load;
  logic              ex_branch_taken, mem_busy;
  logic              f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble, f_to_d_flush;
  logic [1:0][1:0]   pipeline_forward_sel;
  logic [CW-1:0]     stall_cycles, flush_cycles;

  logic [3:0] ctrl;
  logic [1:0] fwd_a, fwd_b;
  assign ctrl  = {f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble, f_to_d_flush};
  assign fwd_a = pipeline_forward_sel[0];
  assign fwd_b = pipeline_forward_sel[1];

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dec_valid           (dec_valid),
    .dec_rs1_addr        (dec_rs1_addr),
    .dec_rs2_addr        (dec_rs2_addr),
    .dec_rs1_used        (dec_rs1_used),
    .dec_rs2_used        (dec_rs2_used),
    .dec_rd_addr         (dec_rd_addr),
    .dec_rd_we           (dec_rd_we),
    .dec_is_load         (dec_is_load),
    .ex_branch_taken     (ex_branch_taken),
    .mem_busy            (mem_busy),
    .f_to_d_enable_ff    (f_to_d_enable_ff),
    .d_to_e_enable_ff    (d_to_e_enable_ff),
    .d_to_e_bubble       (d_to_e_bubble),
    .f_to_d_flush        (f_to_d_flush),
    .pipeline_forward_sel(pipeline_forward_sel),
    .stall_cycles        (stall_cycles),
    .flush_cycles        (flush_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of instructions that have entered execute; [0] is in EX, [1] in MEM
  typedef struct packed {
    bit          v;
    bit [AW-1:0] rd;
    bit          ld;
  } ins_t;

  ins_t pipe[$];
  bit [3:0] e_ctrl;
  int       e_fa, e_fb;
  int       m_stall, m_flush;

  function automatic int ref_fwd(bit used, bit [AW-1:0] a);
    if (!used || a == 0) return 0;
    if (pipe[0].v && pipe[0].rd == a && !pipe[0].ld) return 1;
    if (pipe[1].v && pipe[1].rd == a) return pipe[1].ld ? 3 : 2;
    return 0;
  endfunction

  function automatic void predict();
    bit lu;
    lu = dec_valid && pipe[0].v && pipe[0].ld &&
         ((dec_rs1_used && dec_rs1_addr != 0 && pipe[0].rd == dec_rs1_addr) ||
          (dec_rs2_used && dec_rs2_addr != 0 && pipe[0].rd == dec_rs2_addr));
    e_fa = rst ? ref_fwd(dec_rs1_used, dec_rs1_addr) : 0;
    e_fb = rst ? ref_fwd(dec_rs2_used, dec_rs2_addr) : 0;
    if (!rst)                 e_ctrl = 4'b0011;
    else if (mem_busy)        e_ctrl = 4'b0000;
    else if (ex_branch_taken) e_ctrl = 4'b1111;
    else if (lu)              e_ctrl = 4'b0110;
    else                      e_ctrl = 4'b1100;
  endfunction

  task automatic settle();
    #2;
    predict();
  endtask

  task automatic tick();
    ins_t n;
    predict();
    @(posedge clk);
    if (!rst) begin
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      m_stall = 0;
      m_flush = 0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (!e_ctrl[3] && m_stall < MAXC) m_stall++;
      if (e_ctrl[0] && m_flush < MAXC) m_flush++;
`endif
      if (!mem_busy) begin
        n.v  = !e_ctrl[1] && dec_valid && dec_rd_we && dec_rd_addr != 0;
        n.rd = dec_rd_addr;
        n.ld = dec_is_load;
        pipe.push_front(n);
        void'(pipe.pop_back());
      end
    end
    #1;
  endtask

  task automatic set_dec(bit v, bit [AW-1:0] r1, bit u1, bit [AW-1:0] r2, bit u2,
                         bit [AW-1:0] rd, bit we, bit ld);
    dec_valid = v; dec_rs1_addr = r1; dec_rs1_used = u1;
    dec_rs2_addr = r2; dec_rs2_used = u2;
    dec_rd_addr = rd; dec_rd_we = we; dec_is_load = ld;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      set_dec(1, 5'($urandom_range(0, 7)), 1, 5'($urandom_range(0, 7)), 1,
              5'($urandom_range(1, 7)), 1, 1'($urandom_range(0, 1)));
      ex_branch_taken = 1'($urandom_range(0, 1));
      mem_busy        = 1'($urandom_range(0, 1));
      settle();
      checks++; if (ctrl !== 4'b0011) begin errors++; $display("FAIL reset_ctrl got %b want 0011", ctrl); end
      checks++; if ({fwd_b, fwd_a} !== 4'b0000) begin errors++; $display("FAIL reset_fwd got %b want 0000", {fwd_b, fwd_a}); end
      checks++; if (stall_cycles !== '0 || flush_cycles !== '0) begin
        errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles, flush_cycles);
      end
      tick();
    end
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_dec(1, 2, 1, 0, 0, 5, 1, 1);        // lw x5
    settle();
    checks++; if (ctrl !== 4'b1100) begin errors++; $display("FAIL lu_lw_ctrl got %b want 1100", ctrl); end
    tick();
    set_dec(1, 5, 1, 7, 1, 6, 1, 0);        // add x6,x5,x7
    settle();
    checks++; if (ctrl !== 4'b0110) begin errors++; $display("FAIL lu_stall_ctrl got %b want 0110", ctrl); end
    tick();
    settle();
    checks++; if (ctrl !== 4'b1100) begin errors++; $display("FAIL lu_after_ctrl got %b want 1100", ctrl); end
    checks++; if (fwd_a !== 2'd3 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL lu_after_fwd got A=%0d B=%0d want A=3 B=0", fwd_a, fwd_b);
    end
    tick();
  endtask

  task automatic test_forwarding();
    do_reset();
    set_dec(1, 1, 1, 2, 1, 5, 1, 0); tick();      // add x5
    set_dec(1, 5, 1, 5, 1, 8, 1, 0); settle();    // sub x8,x5,x5
    checks++; if (ctrl !== 4'b1100) begin errors++; $display("FAIL fwd_ex_ctrl got %b want 1100", ctrl); end
    checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin
      errors++; $display("FAIL fwd_ex got A=%0d B=%0d want A=1 B=1", fwd_a, fwd_b);
    end
    set_dec(1, 5, 0, 5, 0, 8, 1, 0); settle();    // same operands but unused
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL fwd_unused got A=%0d B=%0d want A=0 B=0", fwd_a, fwd_b);
    end
    do_reset();
    set_dec(1, 1, 1, 2, 1, 5, 1, 0); tick();      // add x5
    set_dec(1, 3, 1, 4, 1, 9, 1, 0); tick();      // independent
    set_dec(1, 5, 1, 5, 1, 8, 1, 0); settle();
    checks++; if (fwd_a !== 2'd2 || fwd_b !== 2'd2) begin
      errors++; $display("FAIL fwd_mem_alu got A=%0d B=%0d want A=2 B=2", fwd_a, fwd_b);
    end
    do_reset();
    set_dec(1, 2, 1, 0, 0, 5, 1, 1); tick();      // lw x5
    set_dec(1, 3, 1, 4, 1, 9, 1, 0); tick();      // independent
    set_dec(1, 7, 1, 5, 1, 8, 1, 0); settle();
    checks++; if (ctrl !== 4'b1100 || fwd_a !== 2'd0 || fwd_b !== 2'd3) begin
      errors++; $display("FAIL fwd_mem_dm got ctrl=%b A=%0d B=%0d want 1100 A=0 B=3", ctrl, fwd_a, fwd_b);
    end
    do_reset();
    set_dec(1, 0, 1, 0, 0, 0, 1, 0); tick();      // addi x0
    set_dec(1, 0, 1, 0, 1, 1, 1, 0); settle();    // add x1,x0,x0
    checks++; if (ctrl !== 4'b1100 || fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL fwd_x0 got ctrl=%b A=%0d B=%0d want 1100 A=0 B=0", ctrl, fwd_a, fwd_b);
    end
    tick();
  endtask

  task automatic test_branch_vs_load();
    do_reset();
    set_dec(1, 2, 1, 0, 0, 5, 1, 1); tick();      // lw x5
    set_dec(1, 5, 1, 7, 1, 6, 1, 0);
    ex_branch_taken = 1'b1;
    settle();
    checks++; if (ctrl !== 4'b1111) begin errors++; $display("FAIL br_lu_ctrl got %b want 1111", ctrl); end
    tick();
    ex_branch_taken = 1'b0;
    settle();
    checks++; if (ctrl !== 4'b1100 || fwd_a !== 2'd3) begin
      errors++; $display("FAIL br_after got ctrl=%b A=%0d want 1100 A=3", ctrl, fwd_a);
    end
    tick();
  endtask

  task automatic test_mem_busy_stall();
    do_reset();
    set_dec(1, 2, 1, 0, 0, 5, 1, 1); tick();      // lw x5
    set_dec(1, 5, 1, 7, 1, 6, 1, 0); tick();      // stall cycle
    for (int i = 0; i < 3; i++) begin
      mem_busy = 1'b1;
      settle();
      checks++; if (ctrl !== 4'b0000 || fwd_a !== 2'd3) begin
        errors++; $display("FAIL busy_hold[%0d] got ctrl=%b A=%0d want 0000 A=3", i, ctrl, fwd_a);
      end
      tick();
    end
    mem_busy = 1'b0;
    settle();
    checks++; if (ctrl !== 4'b1100 || fwd_a !== 2'd3 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL busy_release got ctrl=%b A=%0d B=%0d want 1100 A=3 B=0", ctrl, fwd_a, fwd_b);
    end
    tick();
    settle();
    checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL busy_drain got A=%0d want 0", fwd_a); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_dec(1, 2, 1, 0, 0, 5, 1, 1); tick();
    set_dec(1, 5, 1, 7, 1, 6, 1, 0); tick();      // now in the stall's second cycle
    rst = 1'b0;
    settle();
    checks++; if (ctrl !== 4'b0011 || fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL rst_mid got ctrl=%b A=%0d B=%0d want 0011 A=0 B=0", ctrl, fwd_a, fwd_b);
    end
    checks++; if (stall_cycles !== '0 || flush_cycles !== '0) begin
      errors++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", stall_cycles, flush_cycles);
    end
    tick();
    rst = 1'b1;
    settle();
    checks++; if (ctrl !== 4'b1100 || fwd_a !== 2'd0) begin
      errors++; $display("FAIL rst_release got ctrl=%b A=%0d want 1100 A=0", ctrl, fwd_a);
    end
    for (int k = 0; k < 2; k++) begin
      set_dec(1, 2, 1, 0, 0, 5, 1, 1); tick();
      set_dec(1, 5, 1, 7, 1, 6, 1, 0); tick();
      tick();
    end
    settle();
    checks++; if (int'(stall_cycles) !== EXP_TWO_STALLS || int'(stall_cycles) !== m_stall) begin
      errors++; $display("FAIL two_stalls_cnt got %0d want %0d", stall_cycles, EXP_TWO_STALLS);
    end
    checks++; if (int'(flush_cycles) !== m_flush) begin
      errors++; $display("FAIL two_stalls_flush got %0d want %0d", flush_cycles, m_flush);
    end
  endtask

  task automatic test_counter_saturation();
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < MAXC + 8; i++) tick();
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_busy = 1'b0;
      tick();
    end
    settle();
    checks++; if (int'(stall_cycles) !== m_stall) begin
      errors++; $display("FAIL sat_stall got %0d want %0d", stall_cycles, m_stall);
    end
    checks++; if (int'(flush_cycles) !== m_flush) begin
      errors++; $display("FAIL sat_flush got %0d want %0d", flush_cycles, m_flush);
    end
    ex_branch_taken = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_dec(1'($urandom_range(0, 9) != 0),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 4) != 0),
              1'($urandom_range(0, 2) == 0));
      ex_branch_taken = 1'($urandom_range(0, 9) == 0);
      mem_busy        = 1'($urandom_range(0, 7) == 0);
      settle();
      checks++; if (ctrl !== e_ctrl) begin
        errors++; $display("FAIL rnd_ctrl[%0d] got %b want %b", i, ctrl, e_ctrl);
      end
      checks++; if (int'(fwd_a) !== e_fa || int'(fwd_b) !== e_fb) begin
        errors++; $display("FAIL rnd_fwd[%0d] got A=%0d B=%0d want A=%0d B=%0d", i, fwd_a, fwd_b, e_fa, e_fb);
      end
      checks++; if (int'(stall_cycles) !== m_stall || int'(flush_cycles) !== m_flush) begin
        errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_cycles, flush_cycles, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    pipe.push_back('0);
    pipe.push_back('0);
    m_stall = 0;
    m_flush = 0;
    rst = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_vs_load();
    test_mem_busy_stall();
    test_reset_mid_stall();
    test_counter_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
